gmii_tx_sched: RTL and testbench
================================

Name: gmii_tx_sched

Overview:
Two-source GMII transmit frame scheduler. It sits between the MAC-side frame producers and the RGMII TX DDR output wrapper. It arbitrates whole frames round-robin between source 0 and source 1. For each frame it inserts the preamble and SFD, streams the payload bytes onto gmii_txd/gmii_tx_en, and enforces a minimum inter-frame gap. It also terminates frames cleanly when a source underruns.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 preamble bytes before the SFD (legal range 1..15)
IFG_LEN, 12, minimum number of gmii_tx_en-low cycles between frames (legal range 1..255)

Ports:
gmii_tx_clk  in  1  GMII transmit clock, 125 MHz; all logic is on its rising edge
RES  in  1  asynchronous active-high reset
sched_en  in  1  when high, new frames may be granted; when low, no new grant is made, but a frame in progress completes
s0_data  in  8  source 0 payload byte
s0_valid  in  1  source 0 byte valid; assert with the first byte to request a frame
s0_last  in  1  source 0 final byte of frame; qualified by s0_valid
s0_ready  out  1  source 0 byte accepted when s0_valid and s0_ready are both high
s1_data / s1_valid / s1_last / s1_ready  —  same as source 0, for source 1
gmii_txd  out  8  GMII transmit data, registered
gmii_tx_en  out  1  GMII transmit enable, registered
busy  out  1  high in every state except IDLE
grant_id  out  1  source owning the current or most recent frame
frame_done  out  1  one-cycle pulse in the cycle gmii_tx_en falls after a successful frame
underrun  out  1  one-cycle pulse when a granted source drops valid mid-frame

Behaviour:
- Reset (async, RES=1):
  - gmii_txd=0x00, gmii_tx_en=0, s0_ready=s1_ready=0, busy=0, grant_id=0, frame_done=0, underrun=0.
  - State goes to IDLE; the round-robin pointer favours source 0; all counters are cleared.
  - Reset mid-frame truncates the frame immediately. Nothing is resumed after reset is released.
- States: IDLE, PRE, SFD, DATA, DRAIN, IFG.
- IDLE:
  - A grant is made when sched_en=1 and at least one sX_valid=1.
  - If only one source is valid, it wins.
  - If both are valid, the source the pointer favours wins. The pointer then favours the other source.
  - On a grant: latch grant_id and go to PRE. No bytes are consumed in IDLE (sX_ready=0).
- PRE:
  - gmii_tx_en=1 and gmii_txd=0x55 for exactly PREAMBLE_LEN cycles, then SFD.
- SFD:
  - gmii_txd=0xD5 for one cycle. The granted source's ready is high in this cycle.
  - The state then goes to DATA.
- Byte acceptance and latency:
  - A byte is accepted in any cycle where the granted source has ready=1 and valid=1.
  - An accepted byte appears on gmii_txd in the next cycle. There is exactly one cycle of latency and no bubbles.
  - The first payload byte immediately follows 0xD5.
- DATA:
  - The granted source's ready stays high; the non-granted source's ready is always 0.
  - Accepting a byte with last=1:
    - ready drops in the next cycle.
    - The last byte is driven on gmii_txd in that cycle.
    - gmii_tx_en falls one cycle later, with frame_done pulsing in that cycle.
    - The state goes to IFG.
- Underrun (granted source valid=0 while in DATA or SFD with ready=1):
  - gmii_tx_en=0 and gmii_txd=0x00 from the next cycle; underrun pulses once.
  - The state goes to DRAIN. frame_done does not pulse.
- DRAIN:
  - ready=1 and bytes are accepted and discarded; gmii_tx_en stays 0.
  - When a byte with last=1 is accepted, the state goes to IFG.
- IFG:
  - gmii_tx_en=0 and gmii_txd=0x00.
  - The counter runs so that exactly IFG_LEN cycles of gmii_tx_en=0 separate the last frame byte (or the abort point) from the next preamble byte, when a request is waiting.
  - The next grant decision is made in the final IFG cycle, so back-to-back frames keep the gap at exactly IFG_LEN.
  - If sched_en=0 or no source is valid at that point, the state goes to IDLE.
- Single-byte frame (valid+last on the first beat): 0xD5, then the byte, then gmii_tx_en falls.
- sched_en falling mid-frame: no effect on the current frame.
- Counter widths are sized for the parameter maxima. The IFG counter must not wrap at IFG_LEN=255.

Test Plan:
- Source 0 sends 4 bytes 0x11,0x22,0x33,0x44 with last on 0x44 → gmii_tx_en high for 12 cycles, carrying 7×0x55, 0xD5, 0x11, 0x22, 0x33, 0x44; frame_done pulses as tx_en falls; grant_id=0.
- Both sources hold continuous 3-byte frames → grants alternate 0,1,0,1; exactly 12 tx_en-low cycles between frames; no byte lost or duplicated.
- Source 1 drops valid after 2 of 5 bytes → tx_en falls the next cycle; one underrun pulse; no frame_done; remaining 3 bytes are drained; next frame starts only after 12 idle cycles.
- sched_en=0 while source 0 is valid → no grant, busy=0; raise sched_en → preamble starts in the cycle after the grant. Drop sched_en mid-frame → the frame completes and no new grant follows.
- Assert RES during DATA → all outputs are 0 asynchronously; after release, a pending source-1 request is granted first only if source 0 is idle; the pointer favours source 0.
- Single-byte frame 0xA5 with IFG_LEN=1 and PREAMBLE_LEN=1 → tx_en high for 3 cycles carrying 0x55, 0xD5, 0xA5; the next frame starts after 1 idle cycle.

Source files
------------

// File: rtl/gmii_tx_sched.sv
// Two-source GMII transmit scheduler: round-robin frame grant, preamble/SFD
// insertion, payload streaming, minimum inter-frame gap and underrun abort.
module gmii_tx_sched #(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned IFG_LEN      = 12
) (
   input  logic       gmii_tx_clk,
   input  logic       RES,
   input  logic       sched_en,
   input  logic [7:0] s0_data,
   input  logic       s0_valid,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic [7:0] s1_data,
   input  logic       s1_valid,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       busy,
   output logic       grant_id,
   output logic       frame_done,
   output logic       underrun
);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DRAIN, IFG} state_t;

   localparam logic [3:0] PRE_LOAD       = 4'(PREAMBLE_LEN - 1);
   // After a good frame the first IFG cycle still carries the last byte,
   // so that path needs one more IFG cycle than the abort/drain path.
   localparam logic [7:0] IFG_LOAD_DATA  = 8'(IFG_LEN);
   localparam logic [7:0] IFG_LOAD_DRAIN = 8'(IFG_LEN - 1);

   state_t     state_q, state_d;
   logic [3:0] pre_cnt_q, pre_cnt_d;
   logic [7:0] ifg_cnt_q, ifg_cnt_d;
   logic       grant_q, grant_d;
   logic       ptr_q, ptr_d;
   logic [7:0] txd_q, txd_d;
   logic       tx_en_q, tx_en_d;
   logic       done_q, done_d;
   logic       urun_q, urun_d;

   logic       req_any;
   logic       pick;
   logic       rdy;
   logic       g_valid;
   logic       g_last;
   logic [7:0] g_data;
   logic       launch;

   assign req_any = sched_en && (s0_valid || s1_valid);
   assign pick    = (s0_valid && s1_valid) ? ptr_q : s1_valid;

   assign g_valid = grant_q ? s1_valid : s0_valid;
   assign g_last  = grant_q ? s1_last  : s0_last;
   assign g_data  = grant_q ? s1_data  : s0_data;

   assign rdy      = (state_q == SFD) || (state_q == DATA) || (state_q == DRAIN);
   assign s0_ready = rdy && !grant_q;
   assign s1_ready = rdy && grant_q;

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      ifg_cnt_d = ifg_cnt_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      txd_d     = '0;
      tx_en_d   = 1'b0;
      done_d    = 1'b0;
      urun_d    = 1'b0;
      launch    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_any) launch = 1'b1;
         end
         PRE: begin
            tx_en_d = 1'b1;
            if (pre_cnt_q == '0) begin
               state_d = SFD;
               txd_d   = 8'hD5;
            end else begin
               pre_cnt_d = pre_cnt_q - 4'd1;
               txd_d     = 8'h55;
            end
         end
         SFD, DATA: begin
            if (g_valid) begin
               tx_en_d = 1'b1;
               txd_d   = g_data;
               if (g_last) begin
                  state_d   = IFG;
                  ifg_cnt_d = IFG_LOAD_DATA;
               end else begin
                  state_d = DATA;
               end
            end else begin
               urun_d  = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (g_valid && g_last) begin
               state_d   = IFG;
               ifg_cnt_d = IFG_LOAD_DRAIN;
            end
         end
         IFG: begin
            done_d = tx_en_q;
            if (ifg_cnt_q == '0) begin
               if (req_any) launch = 1'b1;
               else         state_d = IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         grant_d   = pick;
         ptr_d     = ~pick;
         pre_cnt_d = PRE_LOAD;
         state_d   = PRE;
         txd_d     = 8'h55;
         tx_en_d   = 1'b1;
      end
   end

   always_ff @(posedge gmii_tx_clk or posedge RES) begin
      if (RES) begin
         state_q   <= IDLE;
         pre_cnt_q <= '0;
         ifg_cnt_q <= '0;
         grant_q   <= 1'b0;
         ptr_q     <= 1'b0;
         txd_q     <= '0;
         tx_en_q   <= 1'b0;
         done_q    <= 1'b0;
         urun_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         ifg_cnt_q <= ifg_cnt_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         txd_q     <= txd_d;
         tx_en_q   <= tx_en_d;
         done_q    <= done_d;
         urun_q    <= urun_d;
      end
   end

   assign gmii_txd   = txd_q;
   assign gmii_tx_en = tx_en_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;
   assign frame_done = done_q;
   assign underrun   = urun_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Bench for gmii_tx_sched: queued source drivers, frame scoreboard on the
// GMII side, plus a per-cycle vector table on a minimum-parameter instance.
module tb_gmii_tx_sched;

   localparam int unsigned PRE = 7;
   localparam int unsigned IFG = 12;

   logic       clk = 1'b0;
   logic       RES = 1'b0;
   logic       sched_en;
   logic [7:0] s0_data, s1_data;
   logic       s0_valid, s0_last, s0_ready;
   logic       s1_valid, s1_last, s1_ready;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en, busy, grant_id, frame_done, underrun;

   logic       b_sched_en;
   logic [7:0] b_s0_data, b_s1_data;
   logic       b_s0_valid, b_s0_last, b_s0_ready;
   logic       b_s1_valid, b_s1_last, b_s1_ready;
   logic [7:0] b_txd;
   logic       b_tx_en, b_busy, b_grant_id, b_frame_done, b_underrun;

   always #4 clk = ~clk;

   gmii_tx_sched #(.PREAMBLE_LEN(PRE), .IFG_LEN(IFG)) u_dut (
      .gmii_tx_clk(clk), .RES(RES), .sched_en(sched_en),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
      .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .busy(busy), .grant_id(grant_id),
      .frame_done(frame_done), .underrun(underrun)
   );

   gmii_tx_sched #(.PREAMBLE_LEN(1), .IFG_LEN(1)) u_dut_min (
      .gmii_tx_clk(clk), .RES(RES), .sched_en(b_sched_en),
      .s0_data(b_s0_data), .s0_valid(b_s0_valid), .s0_last(b_s0_last), .s0_ready(b_s0_ready),
      .s1_data(b_s1_data), .s1_valid(b_s1_valid), .s1_last(b_s1_last), .s1_ready(b_s1_ready),
      .gmii_txd(b_txd), .gmii_tx_en(b_tx_en), .busy(b_busy), .grant_id(b_grant_id),
      .frame_done(b_frame_done), .underrun(b_underrun)
   );

   typedef struct packed { logic v; logic [7:0] d; logic l; } beat_t;
   typedef struct { bit src; bit aborted; int gap; int len; } frame_t;
   typedef struct {
      logic v; logic [7:0] d; logic l;
      logic en; logic [7:0] txd; logic rdy; logic fd; logic bsy;
   } vec_t;

   beat_t      q0[$];
   beat_t      q1[$];
   frame_t     sb_rec[$];
   logic [7:0] sb_bytes[$];

   int total = 0;
   int bad = 0;
   int fd_cnt = 0;
   int ur_cnt = 0;
   int starts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input bit src, input beat_t b);
      if (src) q1.push_back(b);
      else     q0.push_back(b);
   endtask

   // drop >= 0 inserts one valid-low beat before payload byte 'drop'
   task automatic push_frame(input bit src, input int n, input logic [7:0] base,
                             input logic [7:0] step, input int drop, input int gap);
      frame_t f;
      beat_t  b;
      int     keep;
      keep = (drop >= 0) ? drop : n;
      for (int i = 0; i < n; i++) begin
         if (i == drop) begin
            b = '0;
            push_beat(src, b);
         end
         b.v = 1'b1;
         b.d = base + 8'(i) * step;
         b.l = (i == n - 1);
         push_beat(src, b);
      end
      for (int i = 0; i < int'(PRE); i++) sb_bytes.push_back(8'h55);
      sb_bytes.push_back(8'hD5);
      for (int i = 0; i < keep; i++) sb_bytes.push_back(base + 8'(i) * step);
      f.src = src; f.aborted = (drop >= 0); f.gap = gap; f.len = int'(PRE) + 1 + keep;
      sb_rec.push_back(f);
   endtask

   task automatic wait_done(input string name, input int max);
      int n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && sb_rec.size() == 0 && !busy) && n < max) begin
         @(negedge clk);
         n++;
      end
      check({name, " completes in budget"}, 32'(n < max), 1);
   endtask

   initial begin : drv0
      bit hs;
      forever begin
         @(negedge clk);
         hs = s0_valid && s0_ready;
         @(posedge clk); #1;
         if (q0.size() > 0 && (hs || !q0[0].v)) void'(q0.pop_front());
         if (q0.size() > 0) begin
            s0_valid = q0[0].v; s0_data = q0[0].d; s0_last = q0[0].l;
         end else begin
            s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
         end
      end
   end

   initial begin : drv1
      bit hs;
      forever begin
         @(negedge clk);
         hs = s1_valid && s1_ready;
         @(posedge clk); #1;
         if (q1.size() > 0 && (hs || !q1[0].v)) void'(q1.pop_front());
         if (q1.size() > 0) begin
            s1_valid = q1[0].v; s1_data = q1[0].d; s1_last = q1[0].l;
         end else begin
            s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
         end
      end
   end

   initial begin : mon
      logic [7:0] cap[$];
      logic [7:0] e;
      bit         in_frame;
      int         low;
      int         mism;
      frame_t     f;
      in_frame = 0;
      low = 0;
      forever begin
         @(negedge clk);
         if (RES) begin
            in_frame = 0; cap.delete(); low = 0;
            continue;
         end
         if (frame_done) fd_cnt++;
         if (underrun) ur_cnt++;
         if (gmii_tx_en) begin
            if (!in_frame) begin
               in_frame = 1;
               starts++;
               cap.delete();
               check("frame expected at start", 32'(sb_rec.size() > 0), 1);
               if (sb_rec.size() > 0) begin
                  check("grant_id", grant_id, sb_rec[0].src);
                  if (sb_rec[0].gap >= 0) check("ifg gap", low, sb_rec[0].gap);
               end
            end
            cap.push_back(gmii_txd);
         end else if (in_frame) begin
            in_frame = 0;
            low = 1;
            if (sb_rec.size() > 0) begin
               f = sb_rec.pop_front();
               mism = -1;
               for (int i = 0; i < f.len; i++) begin
                  e = 8'h00;
                  if (sb_bytes.size() > 0) e = sb_bytes.pop_front();
                  if (mism < 0 && (i >= cap.size() || cap[i] !== e)) mism = i;
               end
               check("frame length", cap.size(), f.len);
               check("frame first bad byte index", mism, -1);
               check("frame_done at fall", frame_done, !f.aborted);
               check("underrun at fall", underrun, f.aborted);
            end
         end else begin
            low++;
         end
      end
   end

   initial begin : main
      vec_t tbl[10];
      int   n;
      int   ur0, fd0, st0;

      tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hD5, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 8'hB6, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 8'hB6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 8'hB6, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 8'hB6, 1'b1, 1'b1, 8'hD5, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB6, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

      sched_en = 1'b1;
      s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
      s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
      b_sched_en = 1'b1;
      b_s0_valid = 1'b0; b_s0_data = '0; b_s0_last = 1'b0;
      b_s1_valid = 1'b0; b_s1_data = '0; b_s1_last = 1'b0;

      #3 RES = 1'b1;
      repeat (3) @(negedge clk);
      check("reset tx_en", gmii_tx_en, 0);
      check("reset txd", gmii_txd, 0);
      check("reset busy", busy, 0);
      check("reset s0_ready", s0_ready, 0);
      check("reset s1_ready", s1_ready, 0);
      check("reset grant_id", grant_id, 0);
      check("reset frame_done", frame_done, 0);
      check("reset underrun", underrun, 0);
      RES = 1'b0;
      repeat (2) @(negedge clk);

      // both sources contending: 0,1,0,1 with exact gaps
      push_frame(0, 3, 8'h10, 8'h01, -1, -1);
      push_frame(1, 3, 8'h20, 8'h01, -1, IFG);
      push_frame(0, 3, 8'h30, 8'h01, -1, IFG);
      push_frame(1, 3, 8'h40, 8'h01, -1, IFG);
      wait_done("alternation", 400);

      push_frame(0, 4, 8'h11, 8'h11, -1, -1);
      wait_done("single source frame", 200);

      // source 1 underrun after two bytes, then a clean frame behind it
      ur0 = ur_cnt; fd0 = fd_cnt;
      push_frame(1, 5, 8'h61, 8'h01, 2, -1);
      push_frame(1, 3, 8'h71, 8'h01, -1, 3 + IFG);
      wait_done("underrun", 300);
      check("underrun pulse count", ur_cnt - ur0, 1);
      check("frame_done pulse count", fd_cnt - fd0, 1);

      // sched_en gating
      sched_en = 1'b0;
      push_frame(0, 3, 8'h81, 8'h01, -1, -1);
      push_frame(0, 2, 8'h91, 8'h01, -1, -1);
      repeat (20) @(negedge clk);
      check("no grant while disabled busy", busy, 0);
      check("no grant while disabled tx_en", gmii_tx_en, 0);
      @(posedge clk); #1 sched_en = 1'b1;
      @(negedge clk);
      check("grant cycle busy", busy, 0);
      @(negedge clk);
      check("preamble start busy", busy, 1);
      check("preamble start tx_en", gmii_tx_en, 1);
      check("preamble start txd", gmii_txd, 8'h55);
      repeat (3) @(negedge clk);
      sched_en = 1'b0;
      n = 0;
      while (sb_rec.size() > 1 && n < 200) begin @(negedge clk); n++; end
      check("frame completes after sched_en drop", 32'(n < 200), 1);
      st0 = starts;
      repeat (40) @(negedge clk);
      check("no new grant busy", busy, 0);
      check("no new frame started", starts - st0, 0);
      sched_en = 1'b1;
      wait_done("resume after enable", 200);

      // reset mid-frame
      push_frame(0, 10, 8'hA0, 8'h01, -1, -1);
      n = 0;
      while (!(gmii_tx_en && gmii_txd == 8'hA0) && n < 60) begin @(negedge clk); n++; end
      check("reach DATA before reset", 32'(n < 60), 1);
      #2 RES = 1'b1;
      #1;
      check("async reset tx_en", gmii_tx_en, 0);
      check("async reset txd", gmii_txd, 0);
      check("async reset busy", busy, 0);
      check("async reset s0_ready", s0_ready, 0);
      check("async reset frame_done", frame_done, 0);
      q0.delete(); q1.delete(); sb_rec.delete(); sb_bytes.delete();
      repeat (2) @(negedge clk);
      RES = 1'b0;
      @(negedge clk);
      push_frame(0, 2, 8'hB0, 8'h01, -1, -1);
      push_frame(1, 3, 8'hC0, 8'h01, -1, IFG);
      wait_done("post-reset arbitration", 300);

      // minimum parameters, per-cycle vectors
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         b_s0_valid = tbl[i].v; b_s0_data = tbl[i].d; b_s0_last = tbl[i].l;
         @(negedge clk);
         check($sformatf("min row%0d tx_en", i), b_tx_en, tbl[i].en);
         check($sformatf("min row%0d txd", i), b_txd, tbl[i].txd);
         check($sformatf("min row%0d ready", i), b_s0_ready, tbl[i].rdy);
         check($sformatf("min row%0d frame_done", i), b_frame_done, tbl[i].fd);
         check($sformatf("min row%0d busy", i), b_busy, tbl[i].bsy);
         check($sformatf("min row%0d underrun", i), b_underrun, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
